// File: rtl/oka_div_8bit_seq.sv
// -----------------------------------------------------------------------------
// oka_div_8bit_seq
//   Sequential inverse of the truncated carry-less multiplier
//   (GF(2)[x] mod x^W). Given a product y and a known multiplicand a,
//   recovers b such that clmul(a, b) mod x^W == y, one bit per cycle.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present on in_a / in_y
//   in_ready   out  block idle and able to accept a request
//   in_a       in   divisor polynomial a (bit i = coefficient of x^i)
//   in_y       in   dividend (truncated product) y
//   out_valid  out  result held on out_b / out_err
//   out_ready  in   consumer accepts the result
//   out_b      out  quotient b (0 when out_err)
//   out_err    out  a[0] == 0, a not invertible mod x^W
// -----------------------------------------------------------------------------
module oka_div_8bit_seq #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_b,
  output logic         out_err
);

  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  r_q, r_d;
  logic [W-1:0]  b_q, b_d;
  logic [IW-1:0] i_q, i_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    r_d     = r_q;
    b_d     = b_q;
    i_d     = i_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          r_d     = in_y;
          b_d     = '0;
          i_d     = '0;
          err_d   = ~in_a[0];
          state_d = in_a[0] ? BUSY : DONE;
        end
      end
      BUSY: begin
        // Bits below i are already zero in R, so bit i of the remainder is
        // exactly bit i of the quotient; cancelling it with a*x^i (a[0]=1)
        // clears R[i] and only disturbs higher bits.
        b_d[i_q] = r_q[i_q];
        if (r_q[i_q]) begin
          r_d = r_q ^ (a_q << i_q);
        end
        i_d = i_q + IW'(1);
        if (i_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      r_q     <= r_d;
      b_q     <= b_d;
      i_q     <= i_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_b     = b_q;
  assign out_err   = err_q;

endmodule
